// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus responder: FSM states, default
// geometry of the banked address space, and the fixed data values it returns.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int         Z80_ADDR_W    = 20;
  localparam int         Z80_BANK_W    = 6;
  localparam logic [7:0] Z80_BANK_PORT = 8'hF0;
  localparam int         Z80_TIMEOUT   = 15;

  localparam logic [7:0] IDLE_DATA    = 8'hFF;
  localparam logic [7:0] RST38_OPCODE = 8'hFF;

endpackage

// File: rtl/z80_addr_map.sv
// Combinational CPU-to-physical address translation: the lowest 16 KiB window
// is pinned to bank 0, the other three windows follow the bank register.
module z80_addr_map
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W = Z80_ADDR_W,
  parameter int BANK_W = Z80_BANK_W
) (
  input  logic [15:0]       cpu_addr,
  input  logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] phys_addr
);

  logic [BANK_W-1:0] bank_sel;

  always_comb begin
    bank_sel  = (cpu_addr[15:14] == 2'b00) ? '0 : bank;
    phys_addr = {bank_sel, cpu_addr[13:0]};
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 external-bus responder: decodes memory/I-O/interrupt-acknowledge cycles,
// stretches memory cycles with WAIT_n and forwards them over a req/ack port.
// Optional build macro Z80_RESP_TIMEOUT_EN adds an ack timeout and timeout_err.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int         ADDR_W    = Z80_ADDR_W,
  parameter int         BANK_W    = Z80_BANK_W,
`ifdef Z80_RESP_TIMEOUT_EN
  parameter int         TIMEOUT   = Z80_TIMEOUT,
`endif
  parameter logic [7:0] BANK_PORT = Z80_BANK_PORT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       A,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  input  logic              MREQ_n,
  input  logic              IORQ_n,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic              M1_n,
  input  logic              RFSH_n,
  output logic              WAIT_n,
  output logic [ADDR_W-1:0] ADDR,
  output logic              mem_req,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
`ifdef Z80_RESP_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [BANK_W-1:0] bank
);

  state_t            state, state_nxt;
  logic [7:0]        d_out_nxt;
  logic              d_oe_nxt;
  logic              wait_n_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              mem_req_nxt;
  logic              mem_we_nxt;
  logic [7:0]        mem_wdata_nxt;
  logic [BANK_W-1:0] bank_nxt;
  logic [ADDR_W-1:0] map_addr;

  logic strobe;
  logic port_hit;
  logic [7:0] bank_rd;

`ifdef Z80_RESP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            timeout_err_nxt;
`endif

  z80_addr_map #(
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W)
  ) u_addr_map (
    .cpu_addr  (A),
    .bank      (bank),
    .phys_addr (map_addr)
  );

  assign strobe   = !RD_n || !WR_n;
  assign port_hit = (A[7:0] == BANK_PORT);
  assign bank_rd  = {{(8 - BANK_W){1'b0}}, bank};

  always_comb begin
    state_nxt     = state;
    d_out_nxt     = D_out;
    d_oe_nxt      = D_oe;
    wait_n_nxt    = WAIT_n;
    addr_nxt      = ADDR;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_wdata_nxt = mem_wdata;
    bank_nxt      = bank;
`ifdef Z80_RESP_TIMEOUT_EN
    to_cnt_nxt      = to_cnt;
    timeout_err_nxt = timeout_err;
`endif

    unique case (state)
      IDLE: begin
`ifdef Z80_RESP_TIMEOUT_EN
        to_cnt_nxt = '0;
`endif
        if (!IORQ_n && !M1_n) begin
          d_out_nxt = RST38_OPCODE;
          d_oe_nxt  = 1'b1;
          state_nxt = HOLD;
        end else if (!MREQ_n) begin
          // A refresh cycle (RFSH_n low) falls through here and is ignored.
          if (RFSH_n && strobe) begin
            addr_nxt    = map_addr;
            mem_we_nxt  = !WR_n;
            if (!WR_n) mem_wdata_nxt = D_in;
            mem_req_nxt = 1'b1;
            wait_n_nxt  = 1'b0;
            state_nxt   = REQ;
          end
        end else if (!IORQ_n && strobe) begin
          if (!WR_n) begin
            if (port_hit) bank_nxt = D_in[BANK_W-1:0];
          end else begin
            d_out_nxt = port_hit ? bank_rd : IDLE_DATA;
            d_oe_nxt  = 1'b1;
          end
          state_nxt = HOLD;
        end
      end

      REQ: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          wait_n_nxt  = 1'b1;
          if (!mem_we) begin
            d_out_nxt = mem_rdata;
            d_oe_nxt  = 1'b1;
          end
          state_nxt = HOLD;
`ifdef Z80_RESP_TIMEOUT_EN
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          mem_req_nxt     = 1'b0;
          wait_n_nxt      = 1'b1;
          timeout_err_nxt = 1'b1;
          if (!mem_we) begin
            d_out_nxt = IDLE_DATA;
            d_oe_nxt  = 1'b1;
          end
          state_nxt = HOLD;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
`endif
        end
      end

      HOLD: begin
        // Both strobes must be seen high before another access is decoded.
        if (MREQ_n && IORQ_n) begin
          d_oe_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      D_out     <= IDLE_DATA;
      D_oe      <= 1'b0;
      WAIT_n    <= 1'b1;
      ADDR      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      bank      <= '0;
    end else begin
      state     <= state_nxt;
      D_out     <= d_out_nxt;
      D_oe      <= d_oe_nxt;
      WAIT_n    <= wait_n_nxt;
      ADDR      <= addr_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_wdata <= mem_wdata_nxt;
      bank      <= bank_nxt;
    end
  end

`ifdef Z80_RESP_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= to_cnt_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: a table of single bus cycles plus
// hand-written sequences for wait latency, reset in REQ and the timeout build.
module tb_z80_bus_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;
  logic        MREQ_n, IORQ_n, RD_n, WR_n, M1_n, RFSH_n;
  logic        WAIT_n;
  logic [19:0] ADDR;
  logic        mem_req, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [5:0]  bank;
`ifdef Z80_RESP_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  z80_bus_responder dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .A         (A),
    .D_in      (D_in),
    .D_out     (D_out),
    .D_oe      (D_oe),
    .MREQ_n    (MREQ_n),
    .IORQ_n    (IORQ_n),
    .RD_n      (RD_n),
    .WR_n      (WR_n),
    .M1_n      (M1_n),
    .RFSH_n    (RFSH_n),
    .WAIT_n    (WAIT_n),
    .ADDR      (ADDR),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
`ifdef Z80_RESP_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .bank      (bank)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [7:0]  din;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [7:0]  rdata;
    logic        exp_req;
    logic [19:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wdata;
    logic        exp_oe;
    logic [7:0]  exp_dout;
    logic [5:0]  exp_bank;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    MREQ_n = 1'b1; IORQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    M1_n = 1'b1; RFSH_n = 1'b1;
  endtask

  task automatic release_strobes(input string name);
    @(negedge Clk);
    bus_idle();
    @(posedge Clk); #1;
    chk({name, " D_oe after strobes rise"}, 32'(D_oe), 32'd0);
    @(posedge Clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge Clk);
    A = v.a; D_in = v.din; mem_rdata = v.rdata;
    MREQ_n = v.mreq_n; IORQ_n = v.iorq_n; RD_n = v.rd_n; WR_n = v.wr_n;
    M1_n = v.m1_n; RFSH_n = v.rfsh_n;
    @(posedge Clk); #1;
    chk({v.name, " mem_req"}, 32'(mem_req), 32'(v.exp_req));
    chk({v.name, " WAIT_n"}, 32'(WAIT_n), 32'(!v.exp_req));
    if (v.exp_req) begin
      chk({v.name, " ADDR"}, 32'(ADDR), 32'(v.exp_addr));
      chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.exp_we));
      if (v.exp_we) chk({v.name, " mem_wdata"}, 32'(mem_wdata), 32'(v.exp_wdata));
      repeat (2) @(posedge Clk);
      #1 chk({v.name, " WAIT_n held"}, 32'(WAIT_n), 32'd0);
      @(negedge Clk);
      mem_ack = 1'b1;
      @(posedge Clk); #1;
      mem_ack = 1'b0;
      chk({v.name, " WAIT_n released"}, 32'(WAIT_n), 32'd1);
      chk({v.name, " mem_req dropped"}, 32'(mem_req), 32'd0);
    end
    chk({v.name, " D_oe"}, 32'(D_oe), 32'(v.exp_oe));
    if (v.exp_oe) chk({v.name, " D_out"}, 32'(D_out), 32'(v.exp_dout));
    chk({v.name, " bank"}, 32'(bank), 32'(v.exp_bank));
    release_strobes(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    //            name          a         din    mq io rd wr m1 rf rdata  req addr       we wdata  oe dout   bank
    vecs[0]  = '{"mrd_4123",   16'h4123, 8'h00, 0, 1, 0, 1, 1, 1, 8'h3E, 1, 20'h00123, 0, 8'h00, 1, 8'h3E, 6'h00};
    vecs[1]  = '{"iowr_bank5", 16'h12F0, 8'h05, 1, 0, 1, 0, 1, 1, 8'h00, 0, 20'h00000, 0, 8'h00, 0, 8'h00, 6'h05};
    vecs[2]  = '{"mwr_8001",   16'h8001, 8'hAA, 0, 1, 1, 0, 1, 1, 8'h00, 1, 20'h14001, 1, 8'hAA, 0, 8'h00, 6'h05};
    vecs[3]  = '{"mrd_2000",   16'h2000, 8'h00, 0, 1, 0, 1, 1, 1, 8'h5A, 1, 20'h02000, 0, 8'h00, 1, 8'h5A, 6'h05};
    vecs[4]  = '{"iord_bank",  16'h00F0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h00, 0, 20'h00000, 0, 8'h00, 1, 8'h05, 6'h05};
    vecs[5]  = '{"iord_other", 16'h0012, 8'h00, 1, 0, 0, 1, 1, 1, 8'h00, 0, 20'h00000, 0, 8'h00, 1, 8'hFF, 6'h05};
    vecs[6]  = '{"intack",     16'h0000, 8'h00, 1, 0, 1, 1, 0, 1, 8'h00, 0, 20'h00000, 0, 8'h00, 1, 8'hFF, 6'h05};
    vecs[7]  = '{"refresh",    16'h4567, 8'h00, 0, 1, 0, 1, 1, 0, 8'h00, 0, 20'h00000, 0, 8'h00, 0, 8'h00, 6'h05};
    vecs[8]  = '{"iowr_other", 16'h0033, 8'h07, 1, 0, 1, 0, 1, 1, 8'h00, 0, 20'h00000, 0, 8'h00, 0, 8'h00, 6'h05};
    vecs[9]  = '{"mrd_c7ff",   16'hC7FF, 8'h00, 0, 1, 0, 1, 1, 1, 8'h81, 1, 20'h147FF, 0, 8'h00, 1, 8'h81, 6'h05};
    vecs[10] = '{"iowr_bank3f",16'hABF0, 8'hFF, 1, 0, 1, 0, 1, 1, 8'h00, 0, 20'h00000, 0, 8'h00, 0, 8'h00, 6'h3F};
    vecs[11] = '{"mwr_ffff",   16'hFFFF, 8'h00, 0, 1, 1, 0, 1, 1, 8'h00, 1, 20'hFFFFF, 1, 8'h00, 0, 8'h00, 6'h3F};
    vecs[12] = '{"mreq_prio",  16'h0010, 8'h00, 0, 0, 0, 1, 1, 1, 8'h77, 1, 20'h00010, 0, 8'h00, 1, 8'h77, 6'h3F};

    Reset = 1'b1; A = '0; D_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    bus_idle();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset WAIT_n", 32'(WAIT_n), 32'd1);
    chk("reset D_oe", 32'(D_oe), 32'd0);
    chk("reset D_out", 32'(D_out), 32'hFF);
    chk("reset bank", 32'(bank), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset ADDR", 32'(ADDR), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Wait-state length: ack returned three full cycles after mem_req appears.
    @(negedge Clk);
    A = 16'h4123; MREQ_n = 1'b0; RD_n = 1'b0;
    @(posedge Clk); #1;
    chk("lat mem_req", 32'(mem_req), 32'd1);
    chk("lat ADDR", 32'(ADDR), 32'h00123);
    low_cnt = (WAIT_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 8'h3E;
      end
      @(posedge Clk); #1;
      mem_ack = 1'b0;
      if (WAIT_n == 1'b0) low_cnt++;
    end
    chk("lat WAIT_n low cycles", 32'(low_cnt), 32'd4);
    chk("lat D_out", 32'(D_out), 32'h3E);
    chk("lat D_oe held", 32'(D_oe), 32'd1);
    chk("lat single access", 32'(mem_req), 32'd0);
    release_strobes("lat");

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Stray ack outside REQ.
    @(negedge Clk);
    mem_ack = 1'b1; mem_rdata = 8'h42;
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    chk("stray ack D_oe", 32'(D_oe), 32'd0);
    chk("stray ack WAIT_n", 32'(WAIT_n), 32'd1);

    // Reset while a memory read is outstanding, then a late ack.
    @(negedge Clk);
    A = 16'h0100; MREQ_n = 1'b0; RD_n = 1'b0;
    @(posedge Clk); #1;
    chk("rst-req mem_req", 32'(mem_req), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("rst-req mem_req dropped", 32'(mem_req), 32'd0);
    chk("rst-req WAIT_n", 32'(WAIT_n), 32'd1);
    chk("rst-req bank", 32'(bank), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    bus_idle();
    @(negedge Clk);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    chk("late ack D_oe", 32'(D_oe), 32'd0);
    chk("late ack mem_req", 32'(mem_req), 32'd0);
    chk("late ack WAIT_n", 32'(WAIT_n), 32'd1);

`ifdef Z80_RESP_TIMEOUT_EN
    @(negedge Clk);
    A = 16'h0200; MREQ_n = 1'b0; RD_n = 1'b0;
    @(posedge Clk); #1;
    chk("to err before", 32'(timeout_err), 32'd0);
    low_cnt = (WAIT_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (WAIT_n == 1'b0) low_cnt++;
    end
    chk("to WAIT_n low cycles", 32'(low_cnt), 32'd15);
    chk("to WAIT_n", 32'(WAIT_n), 32'd1);
    chk("to mem_req", 32'(mem_req), 32'd0);
    chk("to D_out", 32'(D_out), 32'hFF);
    chk("to D_oe", 32'(D_oe), 32'd1);
    chk("to timeout_err", 32'(timeout_err), 32'd1);
    release_strobes("to");
    chk("to err sticky", 32'(timeout_err), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
